// File: rtl/fifo_stream_adapter.sv
`default_nettype none
// ==================================================================
// Module : fifo_stream_adapter
// Credit-based FIFO read port to registered valid/ready stream.
// Rev    : 1.0
// ==================================================================
module fifo_stream_adapter #(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int SKID_DEPTH = 3
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              FIFO_EMPTY,
  output logic                              FIFO_REN,
  input  logic [DATA_WIDTH-1:0]             FIFO_R_DATA,
  output logic                              M_VALID,
  input  logic                              M_READY,
  output logic [DATA_WIDTH-1:0]             M_DATA,
  output logic [$clog2(SKID_DEPTH+1)-1:0]   LEVEL
);

  localparam int LVL_W = $clog2(SKID_DEPTH + 1);
  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int SUM_W = LVL_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]      count_q, count_d;
  logic [RD_LATENCY-1:0] pipe_q, pipe_d;
  logic [SUM_W-1:0]      inflight_w;
  logic [SUM_W-1:0]      used_w;
  logic                  ren_w;
  logic                  arrive_w;
  logic                  pop_w;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credits cover both buffered and in-flight words, so a read is only
  // issued when its data is guaranteed a slot, independent of M_READY.
  always_comb begin
    inflight_w = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight_w = inflight_w + SUM_W'(pipe_q[i]);
    end
  end

  assign used_w   = SUM_W'(count_q) + inflight_w;
  assign ren_w    = !RST && !FIFO_EMPTY && (used_w < SUM_W'(SKID_DEPTH));
  assign arrive_w = pipe_q[RD_LATENCY-1] && !RST;
  assign pop_w    = M_VALID && M_READY;

  always_comb begin
    pipe_d   = RD_LATENCY'({pipe_q, ren_w});
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (arrive_w && !pop_w) begin
      count_d = count_q + LVL_W'(1);
    end else if (!arrive_w && pop_w) begin
      count_d = count_q - LVL_W'(1);
    end
    if (arrive_w) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop_w) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pipe_q   <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      pipe_q   <= pipe_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (arrive_w) begin
      mem_q[wr_ptr_q] <= FIFO_R_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (arrive_w) begin
      assert (count_q < LVL_W'(SKID_DEPTH));
    end
  end

  assign FIFO_REN = ren_w;
  assign M_VALID  = (count_q != '0);
  assign M_DATA   = mem_q[rd_ptr_q];
  assign LEVEL    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_adapter.sv
`default_nettype none
// ==================================================================
// Module : tb_fifo_stream_adapter
// Directed bench with a queue-level model of fifo_stream_adapter.
// Rev    : 1.0
// ==================================================================
module tb_fifo_stream_adapter;

  localparam int DW    = 8;
  localparam int DEPTH = 3;

  logic          CLK = 1'b0;
  logic          RST;
  logic          FIFO_EMPTY;
  logic          FIFO_REN;
  logic [DW-1:0] FIFO_R_DATA = '0;
  logic          M_VALID;
  logic          M_READY;
  logic [DW-1:0] M_DATA;
  logic [1:0]    LEVEL;

  fifo_stream_adapter #(
    .DATA_WIDTH (DW),
    .RD_LATENCY (1),
    .SKID_DEPTH (DEPTH)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .FIFO_EMPTY  (FIFO_EMPTY),
    .FIFO_REN    (FIFO_REN),
    .FIFO_R_DATA (FIFO_R_DATA),
    .M_VALID     (M_VALID),
    .M_READY     (M_READY),
    .M_DATA      (M_DATA),
    .LEVEL       (LEVEL)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  logic [DW-1:0] src[$];
  logic [DW-1:0] mq[$];
  logic [DW-1:0] infl[$];
  logic [DW-1:0] got[$];
  int            ren_cyc[$];
  int            fire_cyc[$];

  logic          ren_s  = 1'b0;
  logic          rdy_s  = 1'b0;
  logic          rst_s  = 1'b1;
  logic          exp_ren;
  logic          hold_pend = 1'b0;
  logic [DW-1:0] hold_data = '0;
  logic [DW-1:0] w;
  int            rel_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare DUT against the model mid-cycle and capture what the next edge consumes.
  always @(negedge CLK) begin
    if (chk_en) begin
      exp_ren = !RST && !FIFO_EMPTY && ((mq.size() + infl.size()) < DEPTH);
      chk("fifo_ren", {31'd0, FIFO_REN}, {31'd0, exp_ren});
      chk("m_valid", {31'd0, M_VALID}, (mq.size() != 0) ? 32'd1 : 32'd0);
      chk("level", {30'd0, LEVEL}, mq.size());
      if (mq.size() != 0) chk("m_data", {24'd0, M_DATA}, {24'd0, mq[0]});
      if (hold_pend) begin
        chk("hold_valid", {31'd0, M_VALID}, 32'd1);
        chk("hold_data", {24'd0, M_DATA}, {24'd0, hold_data});
      end
      hold_pend = M_VALID && !M_READY && !RST;
      hold_data = M_DATA;
      ren_s = FIFO_REN;
      rdy_s = M_READY;
      rst_s = RST;
      if (M_VALID && M_READY) begin
        got.push_back(M_DATA);
        fire_cyc.push_back(cyc);
      end
      if (FIFO_REN) ren_cyc.push_back(cyc);
    end
  end

  // FIFO read-side environment plus model state advance, just after each edge.
  always @(posedge CLK) begin
    #1;
    cyc++;
    if (rst_s) begin
      mq.delete();
      infl.delete();
    end else begin
      if (mq.size() != 0 && rdy_s) w = mq.pop_front();
      if (infl.size() != 0) mq.push_back(infl.pop_front());
    end
    if (ren_s && src.size() != 0) begin
      w = src.pop_front();
      FIFO_R_DATA = w;
      if (!rst_s) infl.push_back(w);
    end else begin
      FIFO_R_DATA = DW'($urandom);
    end
    FIFO_EMPTY = (src.size() == 0);
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic clear_logs();
    got.delete();
    fire_cyc.delete();
    ren_cyc.delete();
  endtask

  task automatic wait_got(input int n, input int budget, input string name);
    int k = 0;
    while (got.size() < n && k < budget) begin
      step();
      k++;
    end
    chk(name, got.size(), n);
  endtask

  initial begin
    RST        = 1'b1;
    FIFO_EMPTY = 1'b0;
    M_READY    = 1'b1;
    src.push_back(8'hA5);
    step();
    chk_en = 1'b1;

    // Reset held with a non-empty FIFO
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("rst_ren", {31'd0, FIFO_REN}, 32'd0);
      chk("rst_valid", {31'd0, M_VALID}, 32'd0);
      chk("rst_level", {30'd0, LEVEL}, 32'd0);
      step();
    end
    RST = 1'b0;
    @(negedge CLK);
    chk("ren_on_release", {31'd0, FIFO_REN}, 32'd1);
    rel_cyc = cyc;

    // Single word A5: valid exactly two cycles after the read, for one cycle
    repeat (6) step();
    chk("single_reads", ren_cyc.size(), 1);
    chk("single_words", fire_cyc.size(), 1);
    if (fire_cyc.size() == 1) begin
      chk("single_latency", fire_cyc[0], rel_cyc + 2);
      chk("single_data", {24'd0, got[0]}, 32'h0000_00A5);
    end
    chk("single_level", {30'd0, LEVEL}, 32'd0);

    // Streaming 0x00..0x0F with M_READY held high
    clear_logs();
    for (int i = 0; i < 16; i++) src.push_back(8'(i));
    wait_got(16, 60, "stream_count");
    for (int i = 0; i < 16 && i < got.size(); i++) begin
      chk("stream_data", {24'd0, got[i]}, i);
      chk("stream_gap", fire_cyc[i], fire_cyc[0] + i);
    end
    repeat (2) step();

    // Backpressure: 8 words, sink stalled
    M_READY = 1'b0;
    clear_logs();
    for (int i = 0; i < 8; i++) src.push_back(8'(8'h20 + i));
    repeat (10) step();
    @(negedge CLK);
    chk("bp_reads", ren_cyc.size(), 3);
    chk("bp_level", {30'd0, LEVEL}, 32'd3);
    chk("bp_valid", {31'd0, M_VALID}, 32'd1);
    chk("bp_data", {24'd0, M_DATA}, 32'h0000_0020);
    chk("bp_ren_low", {31'd0, FIFO_REN}, 32'd0);
    step();
    M_READY = 1'b1;
    wait_got(8, 40, "bp_count");
    for (int i = 0; i < 8 && i < got.size(); i++) chk("bp_order", {24'd0, got[i]}, 32'h20 + i);
    repeat (2) step();

    // Alternating ready over a 10-word burst
    clear_logs();
    for (int i = 0; i < 10; i++) src.push_back(8'(8'h40 + i));
    for (int k = 0; k < 80 && got.size() < 10; k++) begin
      M_READY = (k % 2 == 0);
      step();
    end
    M_READY = 1'b1;
    chk("alt_count", got.size(), 10);
    for (int i = 0; i < 10 && i < got.size(); i++) chk("alt_order", {24'd0, got[i]}, 32'h40 + i);
    repeat (3) step();

    // Reset with two words buffered and one in flight
    clear_logs();
    M_READY = 1'b0;
    src.push_back(8'h60);
    src.push_back(8'h61);
    src.push_back(8'h62);
    for (int k = 0; k < 20 && LEVEL != 2'd2; k++) step();
    chk("mr_level2", {30'd0, LEVEL}, 32'd2);
    chk("mr_reads", ren_cyc.size(), 3);
    RST = 1'b1;
    step();
    RST = 1'b0;
    @(negedge CLK);
    chk("mr_valid", {31'd0, M_VALID}, 32'd0);
    chk("mr_level", {30'd0, LEVEL}, 32'd0);
    step();
    clear_logs();
    M_READY = 1'b1;
    src.push_back(8'h63);
    wait_got(1, 20, "mr_count");
    repeat (6) step();
    chk("mr_only_new", got.size(), 1);
    if (got.size() != 0) chk("mr_data", {24'd0, got[0]}, 32'h0000_0063);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/fifo_stream_adapter.md
Name: fifo_stream_adapter

Overview:
- Read-side consumer for the team's dual-clock `fifo`. It runs in the FIFO read-clock domain.
- It converts the FIFO's EMPTY/REN/R_DATA read port into a registered valid/ready stream (M_VALID/M_READY/M_DATA).
- Internal skid buffer is first-word-fall-through.
- FIFO reads are issued on a credit basis, so FIFO_REN never depends combinationally on M_READY.
- Full throughput is sustained despite the RAM read latency.

Parameters:
- DATA_WIDTH, 8, width of FIFO_R_DATA and M_DATA.
- RD_LATENCY, 1, cycles from an accepted FIFO read to FIFO_R_DATA valid; legal range 1..4.
- SKID_DEPTH, 3, skid buffer entries; legal range ≥ RD_LATENCY+1; full throughput requires ≥ RD_LATENCY+2.

Ports:
- CLK  input  1  clock; same clock as the FIFO read side.
- RST  input  1  reset, synchronous, active-high.
- FIFO_EMPTY  input  1  FIFO empty flag.
- FIFO_REN  output  1  FIFO read enable.
- FIFO_R_DATA  input  DATA_WIDTH  FIFO read data, valid RD_LATENCY cycles after an issued read.
- M_VALID  output  1  output stream valid.
- M_READY  input  1  output stream ready.
- M_DATA  output  DATA_WIDTH  output stream data.
- LEVEL  output  $clog2(SKID_DEPTH+1)  entries currently held in the skid buffer.

Behaviour:
- Reset: one clock; reset is synchronous and active-high (CLK, RST). While RST=1 at a rising edge, clear the following:
  - buffer count, read/write pointers and the in-flight pipeline;
  - M_VALID=0, LEVEL=0, FIFO_REN=0 (forced low during RST);
  - M_DATA is don't-care.
- Reset mid-operation: any read in flight is discarded; its data never appears on M_DATA.
- Issue rule (combinational):
  - FIFO_REN = !RST && !FIFO_EMPTY && (count + inflight < SKID_DEPTH).
  - inflight = number of set bits in an RD_LATENCY-deep valid shift register.
  - FIFO_REN must not depend on M_READY.
- In-flight pipeline: stage 0 loads FIFO_REN each cycle. When the last stage is set, FIFO_R_DATA is written at wr_ptr that cycle.
- Pop: when M_VALID && M_READY, advance rd_ptr.
- count update: count_nxt = count + arrive − pop. Simultaneous arrive and pop leave count unchanged.
- Credit limit: arrival into a full buffer is impossible. Assert (simulation only) that count < SKID_DEPTH whenever arrive=1.
- Pointers: rd_ptr/wr_ptr wrap from SKID_DEPTH−1 to 0. SKID_DEPTH need not be a power of two.
- Output timing:
  - M_VALID = (count != 0); M_DATA = mem[rd_ptr]; both driven from registers.
  - Earliest M_VALID after FIFO_REN is RD_LATENCY+1 cycles: data registered into the buffer, then visible.
- AXI-style hold: once M_VALID=1, M_VALID and M_DATA stay stable until M_READY=1.
- Ordering: strict FIFO order; no drop, no duplication.
- Throughput: with SKID_DEPTH ≥ RD_LATENCY+2, a non-empty FIFO and M_READY held 1 give one word per cycle in steady state.
- Backpressure: with M_READY=0, at most SKID_DEPTH words are in count+inflight; FIFO_REN then stays 0.
- FIFO_EMPTY lag: FIFO_EMPTY is trusted as given. Reads are only issued while it is 0.
- LEVEL = count, registered.

Test Plan:
- Reset: hold RST=1 for 3 cycles with FIFO_EMPTY=0 → FIFO_REN=0, M_VALID=0, LEVEL=0 throughout; first FIFO_REN=1 in the cycle RST drops.
- Single word: FIFO holds 0xA5, M_READY=1, RD_LATENCY=1 → FIFO_REN pulses once; M_VALID=1 with M_DATA=0xA5 exactly 2 cycles later for 1 cycle; LEVEL returns to 0.
- Streaming: FIFO preloaded 0x00..0x0F, M_READY=1 → 16 consecutive M_VALID cycles carrying 0x00..0x0F in order, no bubbles after the first word.
- Backpressure: FIFO holds 8 words, M_READY=0 → exactly 3 FIFO_REN pulses, LEVEL=3, M_VALID=1 with M_DATA=word0 stable. Then M_READY=1 → remaining 8 words delivered in order with no loss.
- Alternating M_READY (1,0,1,0…) with a 10-word burst → all 10 words delivered in order; M_DATA never changes while M_VALID=1 and M_READY=0.
- Mid-stream reset: RST=1 for 1 cycle while one read is in flight and LEVEL=2 → next cycle M_VALID=0, LEVEL=0, and the in-flight word never appears on M_DATA.
